reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The parameter BIT_WIDTH SHALL default to 32 and set the data width of every requester and of the shared register.
REQ-002 The parameter LOCK_MAX SHALL default to 4 and set the maximum number of consecutive grants to one locking requester.
REQ-003 The port clk SHALL be a 1-bit input and the single clock; all state updates on posedge clk.
REQ-004 The port reset SHALL be a 1-bit input, synchronous and active-high.
REQ-005 The port req SHALL be a 4-bit input; bit i = requester i wants one write.
REQ-006 The port lock SHALL be a 4-bit input; bit i = requester i asks to keep ownership for the next grant; it is ignored unless req[i] is also asserted.
REQ-007 The port reqData SHALL be a 4*BIT_WIDTH-bit input; slice [i*BIT_WIDTH +: BIT_WIDTH] = requester i data.
REQ-008 The port grant SHALL be a 4-bit registered output, one-hot or zero; bit i = requester i's data is on regDataIn this cycle.
REQ-009 The port regWrtEn SHALL be a 1-bit registered output driving the shared register's write enable.
REQ-010 The port regDataIn SHALL be a BIT_WIDTH-bit registered output driving the shared register's data input.
REQ-011 The port owner SHALL be a 2-bit registered output giving the index of the last granted requester.

Function
REQ-012 The block SHALL hold a 2-bit round-robin pointer ptr, a 2-bit owner register and a lock counter lockCnt sized for 0..LOCK_MAX.
REQ-013 At each non-reset posedge with req==0, the block SHALL set grant=0 and regWrtEn=0, hold regDataIn, hold ptr and owner, and clear lockCnt.
REQ-014 At each non-reset posedge with req!=0, the block SHALL select exactly one winner W.
REQ-015 Winner selection SHALL use the lock case when lockCnt>0, lockCnt<LOCK_MAX, req[owner]=1 and lock[owner]=1; then W=owner.
REQ-016 Winner selection SHALL otherwise use round-robin: W = the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 modulo 4.
REQ-017 On selecting W, the block SHALL register grant=onehot(W), regWrtEn=1, regDataIn=reqData slice W, owner=W and ptr=(W+1) mod 4.
REQ-018 Arbitration latency SHALL be 1 cycle: req sampled at edge N appears as grant/regWrtEn during cycle N+1, and the shared register captures at edge N+2.
REQ-019 The lock counter SHALL be updated as follows:
- if W is granted with lock[W]=1 and W equals the previous owner, lockCnt increments;
- if W is granted with lock[W]=1 and W differs from the previous owner, lockCnt is set to 1;
- if W is granted with lock[W]=0, lockCnt is cleared.
REQ-020 When lockCnt reaches LOCK_MAX, the block SHALL force round-robin for the next arbitration; the pointer is already past the owner, so the owner loses priority.
REQ-021 Requester i SHALL hold req[i] and its data stable until it observes grant[i]=1.
REQ-022 A req[i] still high during a cycle with grant[i]=1 SHALL be a new request.
REQ-023 At most one grant bit SHALL be set in any cycle, and regWrtEn SHALL equal |grant in every cycle.
REQ-024 The block SHALL never grant a requester whose req bit was 0 at the arbitration edge.
REQ-025 Any non-zero req pattern SHALL be granted within 4 arbitration edges when lock=0, and within 4*LOCK_MAX edges otherwise.

Reset
REQ-026 With reset=1 at a posedge, the block SHALL clear grant, regWrtEn, regDataIn, owner, ptr and lockCnt to 0, regardless of req and lock.
REQ-027 A grant in flight when reset asserts SHALL be dropped: regWrtEn=0 in the cycle after the reset edge, and the pending request is not replayed.
REQ-028 The first arbitration after reset release SHALL start the round-robin scan at requester 0.

Verification
REQ-029 Scenario single request: reset, then req=0010 with reqData[1]=0x1234 for one edge -> next cycle grant=0010, regWrtEn=1, regDataIn=0x1234; following cycle grant=0 and regWrtEn=0.
REQ-030 Scenario round-robin: after reset, req=1111 held constant with lock=0 -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
REQ-031 Scenario lock limit: req=1111, lock=0100, LOCK_MAX=4 -> grants 0001, 0010, 0100, 0100, 0100, 0100, then 1000.
REQ-032 Scenario skip idle requesters: ptr=1, req=1001 -> grant 1000 first, then 0001.
REQ-033 Scenario reset mid-operation: req=1111, reset asserted in the cycle grant=0100 -> cycle after the reset edge has grant=0, regDataIn=0; after release the next grant is 0001.
REQ-034 Scenario idle: req=0 for 10 cycles -> regWrtEn stays 0, regDataIn holds its last value, lockCnt=0.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Four-requester arbiter for one shared register write port.
// It uses round-robin order, and a requester can hold a lock for up to LOCK_MAX consecutive grants.
module reg_write_arbiter #(
    parameter int BIT_WIDTH = 32,
    parameter int LOCK_MAX  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             req,
    input  logic [3:0]             lock,
    input  logic [4*BIT_WIDTH-1:0] reqData,
    output logic [3:0]             grant,
    output logic                   regWrtEn,
    output logic [BIT_WIDTH-1:0]   regDataIn,
    output logic [1:0]             owner
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

    logic [BIT_WIDTH-1:0] req_data_arr [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slice
            assign req_data_arr[gi] = reqData[gi*BIT_WIDTH +: BIT_WIDTH];
        end
    endgenerate

    logic [1:0]           ptr_q, ptr_d;
    logic [1:0]           owner_q, owner_d;
    logic [CNT_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic [3:0]           grant_q, grant_d;
    logic                 wen_q, wen_d;
    logic [BIT_WIDTH-1:0] data_q, data_d;
    logic [1:0]           winner;
    logic [1:0]           idx;
    logic                 lock_hold;
    logic                 found;

    always_comb begin
        lock_hold  = (lock_cnt_q != '0) && (lock_cnt_q < CNT_MAX) && req[owner_q] && lock[owner_q];
        winner     = owner_q;
        found      = 1'b0;
        idx        = ptr_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        grant_d    = 4'b0000;
        wen_d      = 1'b0;
        data_d     = data_q;

        if (!lock_hold) begin
            for (int k = 0; k < 4; k++) begin
                idx = ptr_q + 2'(k);
                if (!found && req[idx]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end

        if (req == 4'b0000) begin
            lock_cnt_d = '0;
        end else begin
            grant_d = 4'b0001 << winner;
            wen_d   = 1'b1;
            data_d  = req_data_arr[winner];
            owner_d = winner;
            ptr_d   = winner + 2'd1;
            // The counter saturates so a lone locker that keeps winning round-robin stays forced to round-robin.
            if (lock[winner]) begin
                if (winner == owner_q)
                    lock_cnt_d = (lock_cnt_q == CNT_MAX) ? CNT_MAX : lock_cnt_q + 1'b1;
                else
                    lock_cnt_d = CNT_W'(1);
            end else begin
                lock_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            grant_q    <= '0;
            wen_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            grant_q    <= grant_d;
            wen_q      <= wen_d;
            data_q     <= data_d;
        end
    end

    assign grant     = grant_q;
    assign regWrtEn  = wen_q;
    assign regDataIn = data_q;
    assign owner     = owner_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter.
// It runs directed scenarios and then randomized requesters against a behavioural model.
module tb_reg_write_arbiter;
    localparam int W  = 32;
    localparam int LM = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [3:0]     req = '0;
    logic [3:0]     lock = '0;
    logic [4*W-1:0] reqData = '0;
    logic [3:0]     grant;
    logic           regWrtEn;
    logic [W-1:0]   regDataIn;
    logic [1:0]     owner;

    reg_write_arbiter #(.BIT_WIDTH(W), .LOCK_MAX(LM)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .reqData(reqData),
        .grant(grant), .regWrtEn(regWrtEn), .regDataIn(regDataIn), .owner(owner)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state, advanced once per clock edge from the inputs seen at that edge.
    logic [3:0]   m_grant = '0;
    logic         m_wen = 1'b0;
    logic [W-1:0] m_data = '0;
    int           m_ptr = 0, m_owner = 0, m_cnt = 0;
    logic [W-1:0] rq_data [4];

    task automatic model_update();
        int w;
        w = -1;
        if (reset) begin
            m_grant = '0; m_wen = 1'b0; m_data = '0; m_ptr = 0; m_owner = 0; m_cnt = 0;
        end else if (req == 4'b0000) begin
            m_grant = '0; m_wen = 1'b0; m_cnt = 0;
        end else begin
            if (m_cnt > 0 && m_cnt < LM && req[m_owner] && lock[m_owner]) w = m_owner;
            for (int k = 0; k < 4; k++)
                if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            if (lock[w]) m_cnt = (w == m_owner) ? ((m_cnt + 1 > LM) ? LM : m_cnt + 1) : 1;
            else         m_cnt = 0;
            m_grant = 4'(1 << w);
            m_wen   = 1'b1;
            m_data  = reqData[w*W +: W];
            m_owner = w;
            m_ptr   = (w + 1) % 4;
        end
    endtask

    task automatic pack_data();
        for (int i = 0; i < 4; i++) reqData[i*W +: W] = rq_data[i];
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; lock = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // Prime the outputs with a grant, then reset while requests are still active.
        for (int i = 0; i < 4; i++) rq_data[i] = $urandom;
        pack_data();
        req = 4'b0100; lock = 4'b0100;
        tick();
        reset = 1'b1; req = 4'($urandom); lock = 4'($urandom);
        tick();
        n_checks++;
        if ({grant, regWrtEn, regDataIn, owner} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: grant=%b wen=%b data=%h owner=%0d, required all zero",
                     grant, regWrtEn, regDataIn, owner);
        end
        n_checks++;
        if (dut.lock_cnt_q !== '0) begin
            n_fail++;
            $display("FAIL reset_lockcnt: got %0d required 0", dut.lock_cnt_q);
        end
        $display("reset: grant=%b wen=%b data=%h", grant, regWrtEn, regDataIn);
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < 4; i++) rq_data[i] = $urandom;
        rq_data[1] = 32'h1234;
        pack_data();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        n_checks++;
        if (grant !== 4'b0010 || regWrtEn !== 1'b1 || regDataIn !== 32'h1234) begin
            n_fail++;
            $display("FAIL single_grant: grant=%b wen=%b data=%h, required 0010 1 00001234",
                     grant, regWrtEn, regDataIn);
        end
        tick();
        n_checks++;
        if (grant !== 4'b0000 || regWrtEn !== 1'b0 || regDataIn !== 32'h1234) begin
            n_fail++;
            $display("FAIL single_release: grant=%b wen=%b data=%h, required 0000 0 00001234",
                     grant, regWrtEn, regDataIn);
        end
        $display("single: data=%h", regDataIn);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111; lock = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (grant !== exp_g[c] || regWrtEn !== 1'b1 || regDataIn !== rq_data[c % 4]) begin
                n_fail++;
                $display("FAIL rr_step%0d: grant=%b data=%h, required %b %h",
                         c, grant, regDataIn, exp_g[c], rq_data[c % 4]);
            end
            $display("rr step %0d: grant=%b", c, grant);
        end
    endtask

    task automatic test_lock_limit();
        logic [3:0] exp_g [7];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
        do_reset();
        req = 4'b1111; lock = 4'b0100;
        for (int c = 0; c < 7; c++) begin
            tick();
            n_checks++;
            if (grant !== exp_g[c]) begin
                n_fail++;
                $display("FAIL lock_step%0d: grant=%b, required %b", c, grant, exp_g[c]);
            end
            $display("lock step %0d: grant=%b owner=%0d", c, grant, owner);
        end
    endtask

    task automatic test_skip_idle();
        do_reset();
        lock = 4'b0000;
        req = 4'b0001;
        tick();
        req = 4'b1001;
        tick();
        n_checks++;
        if (grant !== 4'b1000 || owner !== 2'd3) begin
            n_fail++;
            $display("FAIL skip_first: grant=%b owner=%0d, required 1000 3", grant, owner);
        end
        tick();
        n_checks++;
        if (grant !== 4'b0001 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL skip_second: grant=%b owner=%0d, required 0001 0", grant, owner);
        end
        $display("skip idle: grant=%b", grant);
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1111; lock = 4'b0000;
        tick(); tick(); tick();
        n_checks++;
        if (grant !== 4'b0100) begin
            n_fail++;
            $display("FAIL midreset_pre: grant=%b, required 0100", grant);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (grant !== 4'b0000 || regWrtEn !== 1'b0 || regDataIn !== '0) begin
            n_fail++;
            $display("FAIL midreset_drop: grant=%b wen=%b data=%h, required 0000 0 0",
                     grant, regWrtEn, regDataIn);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_fail++;
            $display("FAIL midreset_restart: grant=%b, required 0001", grant);
        end
        $display("reset mid-op: restart grant=%b", grant);
    endtask

    task automatic test_idle();
        logic [W-1:0] held;
        do_reset();
        req = 4'b0100; lock = 4'b0100;
        tick(); tick();
        held = rq_data[2];
        req = 4'b0000; lock = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (regWrtEn !== 1'b0 || grant !== 4'b0000 || regDataIn !== held || dut.lock_cnt_q !== '0) begin
                n_fail++;
                $display("FAIL idle_c%0d: wen=%b grant=%b data=%h cnt=%0d, required 0 0000 %h 0",
                         c, regWrtEn, grant, regDataIn, dut.lock_cnt_q, held);
            end
        end
        $display("idle: data held=%h", regDataIn);
    endtask

    task automatic test_random();
        int age [4];
        do_reset();
        for (int i = 0; i < 4; i++) age[i] = 0;
        req = '0;
        for (int c = 0; c < 400; c++) begin
            // Requesters hold req and data until they see their grant, then may re-request.
            for (int i = 0; i < 4; i++) begin
                if (grant[i] || !req[i]) begin
                    req[i] = ($urandom_range(0, 2) != 0);
                    rq_data[i] = $urandom;
                    age[i] = 0;
                end
            end
            lock = (c % 100 < 50) ? 4'($urandom) : 4'b0000;
            pack_data();
            tick();
            for (int i = 0; i < 4; i++) if (req[i] && !grant[i]) age[i]++;
            n_checks++;
            if (grant !== m_grant || regWrtEn !== m_wen || regDataIn !== m_data || owner !== 2'(m_owner)) begin
                n_fail++;
                $display("FAIL rand_c%0d: grant=%b wen=%b data=%h owner=%0d, required %b %b %h %0d",
                         c, grant, regWrtEn, regDataIn, owner, m_grant, m_wen, m_data, m_owner);
            end
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    n_checks++;
                    if (age[i] > 4 * LM) begin
                        n_fail++;
                        $display("FAIL rand_starve%0d: waited %0d edges, required <= %0d", i, age[i], 4 * LM);
                    end
                end
            end
            $display("rand %0d: req=%b lock=%b grant=%b data=%h", c, req, lock, grant, regDataIn);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rq_data[i] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock_limit();
        test_skip_idle();
        test_reset_mid();
        test_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
